// File: rtl/romulus_pkg.sv
// Shared Romulus definitions: widths, counter constants, LFSR taps, scheduler
// state encoding and the counter-to-TK1 byte mapping.
package romulus_pkg;

  localparam int CNT_W         = 56;
  localparam int TK1_W         = 64;
  localparam int ROUNDS_SKINNY = 40;

  // The block counter restarts at 1 for every new message
  localparam logic [CNT_W-1:0] CNT_ONE = 56'h1;

  // Feedback taps at bit positions 2, 4 and 7; bit 0 always receives the feedback
  localparam logic [CNT_W-1:0] LFSR_TAP_MASK = 56'h00_0000_0000_0094;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_t;

  // Counter bytes go into TK1 least-significant byte first; the last byte is zero
  function automatic logic [TK1_W-1:0] cnt_to_tk1(input logic [CNT_W-1:0] c);
    return {c[7:0], c[15:8], c[23:16], c[31:24], c[39:32], c[47:40], c[55:48], 8'h00};
  endfunction

endpackage

// File: rtl/cnt_expansion.sv
// Per-round TK1 permutation on the 64-bit counter half of TK1.
// The word is viewed as eight byte cells, cell 0 in the top byte; output
// cell i takes input cell PERM[i].
module cnt_expansion
  import romulus_pkg::*;
(
  input  logic [TK1_W-1:0] tk,
  output logic [TK1_W-1:0] tk_perm
);

  localparam int PERM [8] = '{1, 7, 0, 5, 2, 6, 4, 3};

  // Route each byte cell to its permuted position
  always_comb begin
    tk_perm = '0;
    for (int i = 0; i < 8; i++) begin
      tk_perm[TK1_W-1-8*i -: 8] = tk[TK1_W-1-8*PERM[i] -: 8];
    end
  end

endmodule

// File: rtl/cnt_lfsr56.sv
// One step of the 56-bit Romulus block-counter LFSR (multiply by x in GF(2^56)).
// Purely combinational so the Romulus-N and Romulus-M schedulers can share it.
module cnt_lfsr56
  import romulus_pkg::*;
(
  input  logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_next
);

  // Shift up by one, wrap the top bit to bit 0 and fold it into the tap positions
  always_comb begin
    cnt_next = {cnt[CNT_W-2:0], cnt[CNT_W-1]} ^ ({CNT_W{cnt[CNT_W-1]}} & LFSR_TAP_MASK);
  end

endmodule

// File: rtl/cnt_tk1_sched.sv
// Counter TK1 scheduler for Romulus-N: holds the public block counter and walks
// the counter TK1 word through the per-round permutation, one word per round.
module cnt_tk1_sched
  import romulus_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_SKINNY,
  parameter int RW     = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cnt_init,
  input  logic             cnt_inc,
  input  logic             cnt_ld,
  input  logic [CNT_W-1:0] cnt_di,
  input  logic             start,
  input  logic             round_en,
  output logic [TK1_W-1:0] tk1_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic [RW-1:0]    rnd_o,
  output logic             busy,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_step;
  logic [TK1_W-1:0] tk1_q, tk1_d, tk1_perm;
  logic [RW-1:0]    rnd_q, rnd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  sched_state_t     state_q, state_d;

  cnt_lfsr56 u_lfsr (
    .cnt      (cnt_q),
    .cnt_next (cnt_step)
  );

  cnt_expansion u_perm (
    .tk      (tk1_q),
    .tk_perm (tk1_perm)
  );

  // Block counter: restart beats load, load beats increment; independent of the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CNT_ONE;
    end else if (cnt_init) begin
      cnt_q <= CNT_ONE;
    end else if (cnt_ld) begin
      cnt_q <= cnt_di;
    end else if (cnt_inc) begin
      cnt_q <= cnt_step;
    end
  end

  // Schedule state and round-key registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tk1_q   <= '0;
      rnd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tk1_q   <= tk1_d;
      rnd_q   <= rnd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: start loads the expanded counter, round_en steps the permutation;
  // the final round_en leaves tk1/rnd untouched and raises done for one cycle
  always_comb begin
    state_d = state_q;
    tk1_d   = tk1_q;
    rnd_d   = rnd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          tk1_d   = cnt_to_tk1(cnt_q);
          rnd_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (round_en) begin
          if (rnd_q == RW'(ROUNDS - 1)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            tk1_d = tk1_perm;
            rnd_d = rnd_q + RW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tk1_o = tk1_q;
  assign cnt_o = cnt_q;
  assign rnd_o = rnd_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: doc/cnt_tk1_sched.md
Name: cnt_tk1_sched

Overview:
- Upstream/surrounding stage of the counter TK1 expansion in the Romulus-N core. Holds the 56-bit Romulus block counter, an LFSR over GF(2^56).
- On each block start, forms the 64-bit counter TK1 word and walks it through the per-round TK1 permutation for ROUNDS rounds, presenting one round-key word per round to the datapath.
- The counter is public, so it is unshared; this block sits outside the DOM share domain.

Parameters:
- ROUNDS, 40, number of SKINNY-128-384+ rounds per block.
- RW, 6, width of the round counter; must satisfy 2^RW >= ROUNDS.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cnt_init  input  1  restart the counter at 1 (new message).
- cnt_inc  input  1  advance the counter one LFSR step.
- cnt_ld  input  1  load the counter from cnt_di (test/resume).
- cnt_di  input  56  counter load value.
- start  input  1  begin key schedule for one block.
- round_en  input  1  the datapath consumed the current round word; advance.
- tk1_o  output  64  current round TK1 counter word.
- cnt_o  output  56  current counter value.
- rnd_o  output  RW  current round index.
- busy  output  1  schedule in progress.
- done  output  1  one-cycle pulse after the last round is consumed.

Behaviour:
- Reset (asynchronous, rst_n=0) sets: cnt=56'h1, tk1=0, rnd=0, state=IDLE, busy=0, done=0.
- Counter update is one step per clock, with priority cnt_init > cnt_ld > cnt_inc.
- LFSR step, with x = cnt:
  - new[0] = x[55].
  - new[i] = x[i-1] ^ x[55] for i in {2,4,7}.
  - new[i] = x[i-1] for all other i.
- Counter requests are accepted in any state. The update takes effect next cycle and does not disturb an in-flight tk1.
- Expansion: tk1 = {cnt[7:0],cnt[15:8],cnt[23:16],cnt[31:24],cnt[39:32],cnt[47:40],cnt[55:48],8'h00}.
  - The expansion samples the registered cnt, not a same-cycle update.
- IDLE state:
  - start=1: tk1 <= expansion of cnt, rnd <= 0, state <= RUN, busy <= 1.
  - round_en is ignored.
- RUN state:
  - round_en=1 and rnd < ROUNDS-1: tk1 <= per-round TK1 permutation of tk1, rnd <= rnd+1.
  - round_en=1 and rnd == ROUNDS-1: state <= IDLE, busy <= 0, done <= 1 for exactly one cycle. tk1 is held (not permuted), rnd is held.
  - round_en=0: all registers hold.
  - start is ignored.
- Latency:
  - tk1_o is valid the cycle after start.
  - After start, ROUNDS round_en pulses produce done; done is asserted the cycle after the last pulse.
- Back-to-back blocks: start may be asserted in the same cycle done is high (state is IDLE by then).
- Mid-operation reset: everything returns to reset values immediately; no done pulse is emitted.
- Counter wrap: the period is 2^56-1. No overflow flag is provided; the message-length limit is enforced by the top-level controller.

Decomposition:
- Shared package (romulus_pkg) holds:
  - CNT_W=56, TK1_W=64, ROUNDS_SKINNY=40.
  - Counter reset constant CNT_ONE=56'h1.
  - LFSR tap positions {2,4,7}.
  - State encoding IDLE/RUN.
- Sub-modules:
  - Instantiate the existing cnt_expansion module for the per-round permutation.
  - Add one new combinational sub-module, cnt_lfsr56 (56-bit LFSR step), shared with the Romulus-M variant.
  - FSM, round counter and registers are in cnt_tk1_sched itself.

Test Plan:
- Reset then release: cnt_o=56'h1, tk1_o=0, busy=0, done=0. Assert rst_n=0 while the clock is stopped and check the outputs clear asynchronously.
- cnt_inc once from reset gives cnt_o=56'h2. cnt_ld with 56'h80_0000_0000_0000 then cnt_inc gives cnt_o=56'h00_0000_0000_0095. cnt_init, cnt_ld and cnt_inc together give 56'h1.
- cnt=1, pulse start: next cycle tk1_o=64'h0100_0000_0000_0000, rnd_o=0, busy=1. One round_en gives tk1_o equal to the permutation of that value from the golden model, rnd_o=1.
- start, then 40 round_en pulses with random gaps: done high exactly one cycle after the 40th pulse, busy low, rnd_o=39. start during RUN has no effect on rnd_o/tk1_o.
- Back-to-back: start in the done cycle with cnt_inc two cycles earlier gives a new tk1_o built from the incremented counter. cnt_inc during RUN leaves the tk1_o sequence unchanged.
- Reset mid-run at rnd_o=17: busy=0, rnd_o=0, cnt_o=1, no done pulse. A subsequent start behaves as from a fresh reset.
